reg_flag_file: RTL and testbench

Architectural state block that sits directly around the ALU in the single-cycle datapath. It supplies the ALU operands A and B from an 8 x 8-bit register file, and supplies carry_in from a status register. It captures the ALU result R on writeback, and updates the zero and carry flags from the ALU's zero and carry_out. A small flag stack saves and restores {Z,C} around interrupt and subroutine entry/exit.

---
 rtl/reg_flag_file.sv | 177 +++++++++++++++++
 tb/tb_reg_flag_file.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_flag_file.sv
// reg_flag_file
// -------------
// Architectural state that sits around the ALU in the single-cycle datapath:
// an 8-entry register file (register 0 hard-wired to zero) that feeds ALU
// operands A and B, the Z/C status flags (C drives ALU carry_in), and a small
// LIFO flag stack that saves/restores {Z,C} around interrupt and subroutine
// entry/exit.
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   ra_addr/ra_data           read port A (combinational, write-through bypass)
//   rb_addr/rb_data           read port B (combinational, write-through bypass)
//   we, wa, wd                register write port (writes to r0 discarded)
//   z_we, c_we                load Z from alu_zero / C from alu_carry
//   alu_zero, alu_carry       ALU status inputs (registered only)
//   zero_flag, carry_flag     registered Z and C
//   push, pop                 save / restore {Z,C} on the flag stack
//   stack_full, stack_empty   stack occupancy (DEPTH / zero entries)
//   stack_err                 sticky: overflow, underflow or push+pop together

module reg_flag_file #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       ra_addr,
    input  logic [2:0]       rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    input  logic             we,
    input  logic [2:0]       wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             z_we,
    input  logic             c_we,
    input  logic             alu_zero,
    input  logic             alu_carry,
    output logic             zero_flag,
    output logic             carry_flag,
    input  logic             push,
    input  logic             pop,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    // sp counts 0..DEPTH inclusive, so it needs one more bit than an index.
    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] regs_q  [8];
    logic [WIDTH-1:0] regs_d  [8];
    logic [1:0]       stack_q [DEPTH];
    logic [1:0]       stack_d [DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             err_q, err_d;

    // ------------------------------------------------------------------
    // Decode of the stack request
    // ------------------------------------------------------------------
    logic             full, empty;
    logic             push_ok, pop_ok, stack_fault;
    logic             reg_wr;
    logic [IDX_W-1:0] push_idx, pop_idx;

    assign full        = (sp_q == SP_W'(DEPTH));
    assign empty       = (sp_q == '0);
    assign push_ok     = push && !pop && !full;
    assign pop_ok      = pop && !push && !empty;
    // Any other push/pop combination is a fault and leaves the stack alone.
    assign stack_fault = (push && pop) || (push && full) || (pop && empty);
    assign reg_wr      = we && (wa != 3'd0);

    // When full the low bits of sp wrap to 0, but push_idx is then unused
    // and pop_idx (0 - 1) lands correctly on DEPTH-1.
    assign push_idx    = sp_q[IDX_W-1:0];
    assign pop_idx     = sp_q[IDX_W-1:0] - IDX_W'(1);

    // ------------------------------------------------------------------
    // Read ports: combinational with write-through bypass
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] read_port(input logic [2:0] addr);
        if (addr == 3'd0) begin
            return '0;
        end else if (reg_wr && (wa == addr)) begin
            return wd;
        end else begin
            return regs_q[addr];
        end
    endfunction

    assign ra_data = read_port(ra_addr);
    assign rb_data = read_port(rb_addr);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every *_d gets a hold value first so no path leaves it unassigned;
    // that is what keeps this block from inferring latches.
    always_comb begin
        regs_d  = regs_q;
        stack_d = stack_q;
        sp_d    = sp_q;
        z_d     = z_q;
        c_d     = c_q;
        err_d   = err_q;

        if (reg_wr) begin
            regs_d[wa] = wd;
        end

        if (z_we) begin
            z_d = alu_zero;
        end
        if (c_we) begin
            c_d = alu_carry;
        end

        if (push_ok) begin
            // Saves the flags as they stand before this edge's update.
            stack_d[push_idx] = {z_q, c_q};
            sp_d              = sp_q + SP_W'(1);
        end else if (pop_ok) begin
            // A successful pop wins over the flag enables.
            {z_d, c_d} = stack_q[pop_idx];
            sp_d       = sp_q - SP_W'(1);
        end

        if (stack_fault) begin
            err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
            sp_q  <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            sp_q   <= sp_d;
            z_q    <= z_d;
            c_q    <= c_d;
            err_q  <= err_d;
        end
    end

    // NOTE: stack entries are deliberately not reset: resetting sp discards
    // them, and an entry is only ever read after a push has written it.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign zero_flag   = z_q;
    assign carry_flag  = c_q;
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_reg_flag_file.sv
module tb_reg_flag_file;

    typedef enum logic [2:0] {F_RA, F_RB, F_Z, F_C, F_FULL, F_EMPTY, F_ERR} field_e;

    typedef struct {
        string      name;
        field_e     field;
        logic [7:0] value;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ra_addr, rb_addr, wa;
    logic [7:0] ra_data, rb_data, wd;
    logic       we, z_we, c_we, alu_zero, alu_carry;
    logic       zero_flag, carry_flag;
    logic       push, pop;
    logic       stack_full, stack_empty, stack_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    reg_flag_file #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .ra_data    (ra_data),
        .rb_data    (rb_data),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .z_we       (z_we),
        .c_we       (c_we),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .zero_flag  (zero_flag),
        .carry_flag (carry_flag),
        .push       (push),
        .pop        (pop),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .stack_err  (stack_err)
    );

    // ------------------------------------------------------------------
    // Scoreboard monitor: every negedge, drain what the stimulus queued for
    // this cycle and compare against the live DUT outputs.
    // ------------------------------------------------------------------
    function automatic logic [7:0] actual(input field_e f);
        case (f)
            F_RA:    return ra_data;
            F_RB:    return rb_data;
            F_Z:     return {7'd0, zero_flag};
            F_C:     return {7'd0, carry_flag};
            F_FULL:  return {7'd0, stack_full};
            F_EMPTY: return {7'd0, stack_empty};
            default: return {7'd0, stack_err};
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check(e.name, actual(e.field), e.value);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic expect_val(input string name, input field_e f, input logic [7:0] v);
        exp_t e;
        e.name  = name;
        e.field = f;
        e.value = v;
        sb_q.push_back(e);
    endtask

    task automatic expect_flags(input string tag, input logic z, input logic c);
        expect_val({tag, "_z"}, F_Z, {7'd0, z});
        expect_val({tag, "_c"}, F_C, {7'd0, c});
    endtask

    task automatic expect_stack(input string tag, input logic full, input logic empty,
                                input logic err);
        expect_val({tag, "_full"},  F_FULL,  {7'd0, full});
        expect_val({tag, "_empty"}, F_EMPTY, {7'd0, empty});
        expect_val({tag, "_err"},   F_ERR,   {7'd0, err});
    endtask

    // Clears all strobes at the start of each cycle; data/address inputs keep
    // their last values.
    task automatic idle();
        rst  = 1'b0;
        we   = 1'b0;
        z_we = 1'b0;
        c_we = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic set_flags_en(input logic zw, input logic z, input logic cw, input logic c);
        z_we      = zw;
        alu_zero  = z;
        c_we      = cw;
        alu_carry = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        idle();
        rst = 1'b1;
        ra_addr = 3'd0; rb_addr = 3'd0; wa = 3'd0; wd = 8'h00;
        alu_zero = 1'b0; alu_carry = 1'b0;
        tick();

        // Reset state plus same-cycle bypass write to r3.
        idle();
        expect_flags("rst", 1'b0, 1'b0);
        expect_stack("rst", 1'b0, 1'b1, 1'b0);
        we = 1'b1; wa = 3'd3; wd = 8'hA5; ra_addr = 3'd3; rb_addr = 3'd0;
        expect_val("bypass_ra", F_RA, 8'hA5);
        expect_val("r0_rb", F_RB, 8'h00);
        tick();

        // Stored value visible with we low.
        idle();
        expect_val("stored_ra", F_RA, 8'hA5);
        expect_val("r0_rb2", F_RB, 8'h00);
        tick();

        // Write to r0 is discarded, even on the bypass path.
        idle();
        we = 1'b1; wa = 3'd0; wd = 8'hFF; ra_addr = 3'd0;
        expect_val("r0_wr_same", F_RA, 8'h00);
        tick();

        // r0 still zero; port B bypass on r5 while A reads stored r3.
        idle();
        ra_addr = 3'd0; rb_addr = 3'd3;
        expect_val("r0_wr_after", F_RA, 8'h00);
        expect_val("rb_stored", F_RB, 8'hA5);
        tick();
        idle();
        we = 1'b1; wa = 3'd5; wd = 8'h3C; ra_addr = 3'd3; rb_addr = 3'd5;
        expect_val("bypass_rb", F_RB, 8'h3C);
        expect_val("ra_no_bypass", F_RA, 8'hA5);
        tick();

        // Flags: C loads, Z held despite alu_zero=1; nothing visible same cycle.
        idle();
        set_flags_en(1'b0, 1'b1, 1'b1, 1'b1);
        expect_flags("flag_same_cyc", 1'b0, 1'b0);
        tick();
        idle();
        expect_flags("c_load", 1'b0, 1'b1);
        set_flags_en(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        expect_flags("z_load", 1'b1, 1'b1);
        set_flags_en(1'b0, 1'b0, 1'b1, 1'b0);           // Z=1, C=0
        tick();

        // Stack round trip.
        idle();
        expect_flags("pre_push", 1'b1, 1'b0);
        push = 1'b1;
        tick();
        idle();
        expect_stack("push1", 1'b0, 1'b0, 1'b0);
        set_flags_en(1'b1, 1'b0, 1'b1, 1'b1);           // Z=0, C=1
        tick();
        idle();
        expect_flags("changed", 1'b0, 1'b1);
        pop = 1'b1;
        set_flags_en(1'b1, 1'b0, 1'b1, 1'b1);           // must lose to pop
        tick();
        idle();
        expect_flags("popped", 1'b1, 1'b0);
        expect_stack("popped", 1'b0, 1'b1, 1'b0);

        // Push with c_we=1: stacked value is the pre-update C.
        push = 1'b1;
        set_flags_en(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        expect_flags("push_cwe", 1'b1, 1'b1);
        pop = 1'b1;
        tick();
        idle();
        expect_flags("pre_update_c", 1'b1, 1'b0);
        expect_val("rt2_empty", F_EMPTY, 8'd1);

        // Fill the stack with distinct {Z,C} values: {1,0},{0,1},{1,1},{0,0}.
        push = 1'b1; set_flags_en(1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        expect_flags("fill1", 1'b0, 1'b1);
        expect_stack("fill1", 1'b0, 1'b0, 1'b0);
        push = 1'b1; set_flags_en(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        expect_flags("fill2", 1'b1, 1'b1);
        push = 1'b1; set_flags_en(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        expect_flags("fill3", 1'b0, 1'b0);
        expect_stack("fill3", 1'b0, 1'b0, 1'b0);
        push = 1'b1; set_flags_en(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        expect_flags("fill4", 1'b1, 1'b0);
        expect_stack("full", 1'b1, 1'b0, 1'b0);

        // Overflow: error set, stack kept, flag enable still acts.
        push = 1'b1; set_flags_en(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        expect_flags("ovf", 1'b1, 1'b1);
        expect_stack("ovf", 1'b1, 1'b0, 1'b1);

        // Drain in LIFO order.
        pop = 1'b1;
        tick();
        idle();
        expect_flags("pop4", 1'b0, 1'b0);
        expect_stack("pop4", 1'b0, 1'b0, 1'b1);
        pop = 1'b1;
        tick();
        idle();
        expect_flags("pop3", 1'b1, 1'b1);
        pop = 1'b1;
        tick();
        idle();
        expect_flags("pop2", 1'b0, 1'b1);
        pop = 1'b1;
        tick();
        idle();
        expect_flags("pop1", 1'b1, 1'b0);
        expect_stack("drained", 1'b0, 1'b1, 1'b1);

        // Underflow: flags unchanged, error stays.
        pop = 1'b1;
        tick();
        idle();
        expect_flags("unf", 1'b1, 1'b0);
        expect_stack("unf", 1'b0, 1'b1, 1'b1);

        // Reset overrides everything else in the same cycle.
        rst = 1'b1; push = 1'b1; we = 1'b1; wa = 3'd2; wd = 8'h77;
        set_flags_en(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        ra_addr = 3'd3; rb_addr = 3'd2;
        expect_flags("rst2", 1'b0, 1'b0);
        expect_stack("rst2", 1'b0, 1'b1, 1'b0);
        expect_val("rst2_r3", F_RA, 8'h00);
        expect_val("rst2_r2", F_RB, 8'h00);

        // Build sp=2 with entries {0,0},{1,0}, then push+pop together.
        push = 1'b1; set_flags_en(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        expect_flags("sp1", 1'b1, 1'b0);
        push = 1'b1; set_flags_en(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        idle();
        expect_flags("sp2", 1'b1, 1'b1);
        expect_val("sp2_err", F_ERR, 8'd0);
        push = 1'b1; pop = 1'b1; set_flags_en(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        expect_flags("pushpop", 1'b0, 1'b1);
        expect_stack("pushpop", 1'b0, 1'b0, 1'b1);
        pop = 1'b1;
        tick();
        idle();
        expect_flags("pp_pop2", 1'b1, 1'b0);
        expect_val("pp_pop2_empty", F_EMPTY, 8'd0);
        pop = 1'b1;
        tick();
        idle();
        expect_flags("pp_pop1", 1'b0, 1'b0);
        expect_stack("pp_pop1", 1'b0, 1'b1, 1'b1);

        // Mid-sequence reset clears the sticky error.
        rst = 1'b1; push = 1'b1;
        tick();
        idle();
        expect_flags("rst3", 1'b0, 1'b0);
        expect_stack("rst3", 1'b0, 1'b1, 1'b0);
        tick();

        // Bounded wait for the monitor to drain the scoreboard.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (sb_q.size() > 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
